// File: rtl/spi_tx_arbiter.sv
// Round-robin sequencer sharing one SPI transmit engine between NUM_REQ
// requesters. Latches the winner's word and edge shape, holds the engine
// enable for the frame, acknowledges on engine ready or watchdog timeout,
// then enforces an inter-frame gap with the engine held in reset.
module spi_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATASIZE       = 16,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic [NUM_REQ-1:0]           i_Req,
  input  logic [NUM_REQ*DATASIZE-1:0]  i_Data,
  input  logic [NUM_REQ-1:0]           i_EdgeShape,
  output logic [NUM_REQ-1:0]           o_Grant,
  output logic [NUM_REQ-1:0]           o_Ack,
  output logic                         o_Error,
  output logic                         o_Busy,
  output logic                         o_Spi_Enable,
  output logic [DATASIZE-1:0]          o_Spi_Data,
  output logic                         o_Spi_EdgeShape,
  input  logic                         i_Spi_Ready
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]          state;
  logic [PW-1:0]       last;
  logic [TW-1:0]       to_cnt;
  logic [GW-1:0]       gap_cnt;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [DATASIZE-1:0] win_data;
  logic                win_shape;

  // Round-robin pick: first pending request at last+1, last+2, ... (mod NUM_REQ).
  // Nested constant loops keep every index static, so the scan unrolls into a
  // plain priority mux.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_data   = '0;
    win_shape  = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!win_found && i_Req[k] && (k == (32'(last) + i) % NUM_REQ)) begin
          win_found     = 1'b1;
          win_idx       = PW'(k);
          win_onehot[k] = 1'b1;
          win_data      = i_Data[k*DATASIZE +: DATASIZE];
          win_shape     = i_EdgeShape[k];
        end
      end
    end
  end

  // Frame sequencer: IDLE arbitrates, BUSY waits for ready/timeout, GAP holds the engine in reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst_L) begin
      state           <= ST_IDLE;
      last            <= PW'(NUM_REQ - 1);
      to_cnt          <= '0;
      gap_cnt         <= '0;
      o_Grant         <= '0;
      o_Ack           <= '0;
      o_Error         <= 1'b0;
      o_Busy          <= 1'b0;
      o_Spi_Enable    <= 1'b0;
      o_Spi_Data      <= '0;
      o_Spi_EdgeShape <= 1'b0;
    end else begin
      o_Ack   <= '0;
      o_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state           <= ST_BUSY;
            o_Busy          <= 1'b1;
            o_Grant         <= win_onehot;
            o_Spi_Data      <= win_data;
            o_Spi_EdgeShape <= win_shape;
            o_Spi_Enable    <= 1'b1;
            last            <= win_idx;
            to_cnt          <= '0;
          end
        end
        ST_BUSY: begin
          // Ready takes priority over a coincident timeout, so no error then.
          if (i_Spi_Ready || (to_cnt == TO_LAST)) begin
            state        <= ST_GAP;
            o_Ack        <= o_Grant;
            o_Error      <= ~i_Spi_Ready;
            o_Grant      <= '0;
            o_Spi_Enable <= 1'b0;
            gap_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // The ack cycle is gap cycle 0.
          if (gap_cnt == GAP_LAST) begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          o_Busy       <= 1'b0;
          o_Grant      <= '0;
          o_Spi_Enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: a cycle-by-cycle vector table
// followed by directed multi-cycle sequences (round robin, fairness,
// timeout, reset abort, withdrawn request).
module tb_spi_tx_arbiter;

  logic        clk = 1'b0;
  logic        i_Rst_L;
  logic [3:0]  i_Req;
  logic [63:0] i_Data;
  logic [3:0]  i_EdgeShape;
  logic [3:0]  o_Grant;
  logic [3:0]  o_Ack;
  logic        o_Error;
  logic        o_Busy;
  logic        o_Spi_Enable;
  logic [15:0] o_Spi_Data;
  logic        o_Spi_EdgeShape;
  logic        i_Spi_Ready;

  logic [15:0] words [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign i_Data = {words[3], words[2], words[1], words[0]};

  spi_tx_arbiter #(
    .NUM_REQ(4),
    .DATASIZE(16),
    .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(i_Rst_L),
    .i_Req(i_Req),
    .i_Data(i_Data),
    .i_EdgeShape(i_EdgeShape),
    .o_Grant(o_Grant),
    .o_Ack(o_Ack),
    .o_Error(o_Error),
    .o_Busy(o_Busy),
    .o_Spi_Enable(o_Spi_Enable),
    .o_Spi_Data(o_Spi_Data),
    .o_Spi_EdgeShape(o_Spi_EdgeShape),
    .i_Spi_Ready(i_Spi_Ready)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic        en;
    logic [15:0] data;
    logic        shape;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic rdy,
                              input logic [3:0] g, input logic [3:0] a, input logic e,
                              input logic b, input logic en, input logic [15:0] d,
                              input logic s);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.grant = g; v.ack = a;
    v.err = e; v.busy = b; v.en = en; v.data = d; v.shape = s;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b1;
    i_Req = 4'b0000;
    i_Spi_Ready = 1'b0;
    step();
    step();
    i_Rst_L = 1'b0;
  endtask

  // Waits for the next grant, checks it, runs busy_cyc engine cycles, then completes with ready.
  task automatic run_frame(input string tag, input int exp, input logic [3:0] req_during,
                           input int busy_cyc, input int exp_wait);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      if (o_Spi_Enable) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, " grant_wait"}, 32'(got), 32'd1);
    if (!got) return;
    if (exp_wait > 0) chk({tag, " gap_latency"}, n, exp_wait);
    chk({tag, " grant"}, 32'(o_Grant), 32'(1 << exp));
    chk({tag, " data"}, 32'(o_Spi_Data), 32'(words[exp]));
    chk({tag, " shape"}, 32'(o_Spi_EdgeShape), 32'(i_EdgeShape[exp]));
    i_Req = req_during;
    repeat (busy_cyc) begin
      step();
      chk({tag, " en_hold"}, 32'(o_Spi_Enable), 32'd1);
    end
    i_Spi_Ready = 1'b1;
    step();
    chk({tag, " ack"}, 32'(o_Ack), 32'(1 << exp));
    chk({tag, " err"}, 32'(o_Error), 32'd0);
    chk({tag, " en_low"}, 32'(o_Spi_Enable), 32'd0);
    chk({tag, " grant_clr"}, 32'(o_Grant), 32'd0);
    i_Spi_Ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    words[0] = 16'hA5C3;
    words[1] = 16'h1111;
    words[2] = 16'h2222;
    words[3] = 16'h3333;
    i_Rst_L = 1'b1;
    i_Req = 4'b0000;
    i_EdgeShape = 4'b1101;
    i_Spi_Ready = 1'b0;

    //            rst  req     rdy   grant    ack      err   busy  en    data       shape
    vt[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vt[1]  = mk(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
    vt[2]  = mk(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
    vt[3]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1);
    vt[4]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1);
    vt[5]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1);
    vt[6]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1);
    vt[7]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1);
    vt[8]  = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
    vt[9]  = mk(1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
    vt[10] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0);
    vt[11] = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0);
    vt[12] = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0);
    vt[13] = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0);
    vt[14] = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b0);
    vt[15] = mk(1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1);
    vt[16] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 16'h2222, 1'b1);
    vt[17] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h2222, 1'b1);

    for (int r = 0; r < 18; r++) begin
      i_Rst_L = vt[r].rst;
      i_Req = vt[r].req;
      i_Spi_Ready = vt[r].rdy;
      step();
      chk($sformatf("vec%0d grant", r), 32'(o_Grant), 32'(vt[r].grant));
      chk($sformatf("vec%0d ack", r), 32'(o_Ack), 32'(vt[r].ack));
      chk($sformatf("vec%0d err", r), 32'(o_Error), 32'(vt[r].err));
      chk($sformatf("vec%0d busy", r), 32'(o_Busy), 32'(vt[r].busy));
      chk($sformatf("vec%0d en", r), 32'(o_Spi_Enable), 32'(vt[r].en));
      chk($sformatf("vec%0d data", r), 32'(o_Spi_Data), 32'(vt[r].data));
      chk($sformatf("vec%0d shape", r), 32'(o_Spi_EdgeShape), 32'(vt[r].shape));
    end
    i_Spi_Ready = 1'b0;

    // All four requesting continuously: strict rotation with a 5-clk ack-to-grant spacing.
    do_reset();
    i_EdgeShape = 4'b1111;
    i_Req = 4'b1111;
    run_frame("rr f0", 0, 4'b1111, 3, 0);
    run_frame("rr f1", 1, 4'b1111, 3, 5);
    run_frame("rr f2", 2, 4'b1111, 3, 5);
    run_frame("rr f3", 3, 4'b1111, 3, 5);
    run_frame("rr f0b", 0, 4'b0000, 3, 5);

    // req2 held high, req1 joins mid-frame: 2, then 1, then 2 again.
    do_reset();
    i_Req = 4'b0100;
    run_frame("fair a", 2, 4'b0110, 3, 0);
    run_frame("fair b", 1, 4'b0110, 3, 5);
    run_frame("fair c", 2, 4'b0000, 3, 5);

    // Ready never arrives: ack plus error after 64 BUSY cycles, then the gap.
    do_reset();
    i_Req = 4'b0001;
    step();
    chk("to grant", 32'(o_Grant), 32'h1);
    i_Req = 4'b0000;
    repeat (63) step();
    chk("to no_ack_yet", 32'(o_Ack), 32'h0);
    chk("to en_still", 32'(o_Spi_Enable), 32'h1);
    step();
    chk("to ack", 32'(o_Ack), 32'h1);
    chk("to err", 32'(o_Error), 32'h1);
    chk("to en_low", 32'(o_Spi_Enable), 32'h0);
    chk("to grant_clr", 32'(o_Grant), 32'h0);
    step();
    chk("to err_pulse", 32'(o_Error), 32'h0);
    chk("to ack_pulse", 32'(o_Ack), 32'h0);
    chk("to gap_busy1", 32'(o_Busy), 32'h1);
    step();
    step();
    chk("to gap_busy3", 32'(o_Busy), 32'h1);
    step();
    chk("to idle", 32'(o_Busy), 32'h0);

    // Ready on the same cycle as the timeout: ready wins, no error.
    i_Req = 4'b0010;
    step();
    chk("tie grant", 32'(o_Grant), 32'h2);
    i_Req = 4'b0000;
    repeat (63) step();
    i_Spi_Ready = 1'b1;
    step();
    chk("tie ack", 32'(o_Ack), 32'h2);
    chk("tie err", 32'(o_Error), 32'h0);
    i_Spi_Ready = 1'b0;

    // Reset mid-frame: immediate abort, no ack, then req0 beats req3.
    do_reset();
    i_Req = 4'b1000;
    step();
    chk("rst grant3", 32'(o_Grant), 32'h8);
    step();
    step();
    i_Rst_L = 1'b1;
    step();
    chk("rst en", 32'(o_Spi_Enable), 32'h0);
    chk("rst grant", 32'(o_Grant), 32'h0);
    chk("rst ack", 32'(o_Ack), 32'h0);
    chk("rst busy", 32'(o_Busy), 32'h0);
    chk("rst data", 32'(o_Spi_Data), 32'h0);
    i_Rst_L = 1'b0;
    i_Req = 4'b1001;
    step();
    chk("rst req0_wins", 32'(o_Grant), 32'h1);
    chk("rst data0", 32'(o_Spi_Data), 32'hA5C3);
    i_Req = 4'b0000;
    i_Spi_Ready = 1'b1;
    step();
    chk("rst ack0", 32'(o_Ack), 32'h1);
    i_Spi_Ready = 1'b0;

    // Withdrawn request still completes; falling-edge shape latched.
    do_reset();
    i_EdgeShape = 4'b1110;
    i_Req = 4'b0001;
    run_frame("drop", 0, 4'b0000, 4, 0);
    chk("drop shape_hold", 32'(o_Spi_EdgeShape), 32'h0);
    chk("drop data_hold", 32'(o_Spi_Data), 32'hA5C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
